// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the memory access unit
package core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mau_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - lane select and sign/zero extension of a loaded word
module load_extend
  import core_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_BU:   result = {24'd0, byte_sel};
      F3_HU:   result = {16'd0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit driving a single-beat data bus
module mem_access_unit
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_mem_read,
  input  logic        mem_mem_write,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_result,
  output logic        stall_mem,
  output logic        access_err,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_be,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  mau_state_t  state;
  logic [7:0]  cnt;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        access_req, legal, aligned, accept, reject;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] load_val;

  always_comb begin
    access_req = mem_mem_read | mem_mem_write;
    if (mem_mem_write)
      legal = mem_funct3 inside {F3_B, F3_H, F3_W};
    else
      legal = mem_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    case (mem_funct3[1:0])
      2'b01:   aligned = ~mem_alu_result[0];
      2'b10:   aligned = (mem_alu_result[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    accept = (state == ST_IDLE) && access_req && legal && aligned;
    reject = (state == ST_IDLE) && access_req && !(legal && aligned);
    // Loads reuse the size-based lane pattern so the bus sees which bytes are wanted.
    case (mem_funct3[1:0])
      2'b00: begin
        wdata_n = {4{mem_write_data[7:0]}};
        be_n    = 4'b0001 << mem_alu_result[1:0];
      end
      2'b01: begin
        wdata_n = {2{mem_write_data[15:0]}};
        be_n    = mem_alu_result[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_n = mem_write_data;
        be_n    = 4'b1111;
      end
    endcase
  end

  // Gated by reset so the pipeline is released the instant reset asserts.
  assign stall_mem = reset & (accept | (state == ST_REQ));

  load_extend u_load_extend (
    .rdata  (dbus_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .result (load_val)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      cnt             <= 8'd0;
      off_q           <= 2'd0;
      f3_q            <= 3'd0;
      dbus_req        <= 1'b0;
      dbus_we         <= 1'b0;
      dbus_addr       <= 32'd0;
      dbus_wdata      <= 32'd0;
      dbus_be         <= 4'd0;
      mem_read_result <= 32'd0;
      access_err      <= 1'b0;
    end else begin
      access_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dbus_req   <= 1'b1;
            dbus_we    <= mem_mem_write;
            dbus_addr  <= {mem_alu_result[31:2], 2'b00};
            dbus_be    <= be_n;
            dbus_wdata <= wdata_n;
            off_q      <= mem_alu_result[1:0];
            f3_q       <= mem_funct3;
            cnt        <= 8'd0;
            state      <= ST_REQ;
          end else if (reject) begin
            access_err <= 1'b1;
          end
        end
        ST_REQ: begin
          if (dbus_ack) begin
            dbus_req <= 1'b0;
            cnt      <= 8'd0;
            if (!dbus_we) mem_read_result <= load_val;
            state    <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            dbus_req   <= 1'b0;
            access_err <= 1'b1;
            cnt        <= 8'd0;
            if (!dbus_we) mem_read_result <= 32'd0;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        // DONE never looks at the request lines, so a held instruction is not reissued.
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_mem_read, mem_mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result, mem_write_data;
  logic [31:0] mem_read_result;
  logic        stall_mem, access_err;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] model_result = 32'd0;

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_mem_read    (mem_mem_read),
    .mem_mem_write   (mem_mem_write),
    .mem_funct3      (mem_funct3),
    .mem_alu_result  (mem_alu_result),
    .mem_write_data  (mem_write_data),
    .mem_read_result (mem_read_result),
    .stall_mem       (stall_mem),
    .access_err      (access_err),
    .dbus_req        (dbus_req),
    .dbus_we         (dbus_we),
    .dbus_addr       (dbus_addr),
    .dbus_wdata      (dbus_wdata),
    .dbus_be         (dbus_be),
    .dbus_ack        (dbus_ack),
    .dbus_rdata      (dbus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic legal_ok(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    logic code_ok;
    int   size;
    code_ok = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size = 1 << f3[1:0];
    return code_ok && ((a % 32'(size)) == 32'd0);
  endfunction

  function automatic logic [31:0] expect_load(input logic [31:0] rd, input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] b, h;
    b = (rd >> (8 * off)) & 32'h0000_00FF;
    h = (rd >> (16 * off[1])) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  task automatic idle_inputs();
    mem_mem_read   = 1'b0;
    mem_mem_write  = 1'b0;
    mem_funct3     = 3'd0;
    mem_alu_result = 32'd0;
    mem_write_data = 32'd0;
  endtask

  task automatic run_txn(input logic wr, input logic rd, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdata, input int ack_delay);
    logic        ok, tmo;
    int          exp_req, req_cycles, stall_cycles, size;
    logic [31:0] exp_be, exp_wd;
    ok      = legal_ok(wr, f3, addr);
    tmo     = (ack_delay >= TMO);
    exp_req = tmo ? TMO : ack_delay + 1;
    size    = 1 << f3[1:0];
    exp_be  = ((32'd1 << size) - 32'd1) << addr[1:0];
    exp_wd  = (size == 1) ? wd[7:0] * 32'h0101_0101 :
              (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;

    @(negedge clk);
    mem_mem_read = rd; mem_mem_write = wr; mem_funct3 = f3;
    mem_alu_result = addr; mem_write_data = wd; dbus_ack = 1'b0;
    #1;
    if (!ok) begin
      check_eq("rej_stall", 32'(stall_mem), 32'd0);
      check_eq("rej_req", 32'(dbus_req), 32'd0);
      @(negedge clk); idle_inputs(); #1;
      check_eq("rej_err", 32'(access_err), 32'd1);
      check_eq("rej_req_after", 32'(dbus_req), 32'd0);
      check_eq("rej_result", mem_read_result, model_result);
      @(negedge clk); #1;
      check_eq("rej_err_pulse", 32'(access_err), 32'd0);
      return;
    end
    check_eq("acc_stall", 32'(stall_mem), 32'd1);
    check_eq("acc_req_idle", 32'(dbus_req), 32'd0);
    stall_cycles = 1;
    req_cycles   = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      dbus_ack   = (k == ack_delay);
      dbus_rdata = dbus_ack ? rdata : $urandom;
      #1;
      if (!dbus_req) break;
      req_cycles++;
      if (stall_mem) stall_cycles++;
      check_eq("bus_addr", dbus_addr, {addr[31:2], 2'b00});
      check_eq("bus_we", 32'(dbus_we), 32'(wr));
      if (wr) begin
        check_eq("bus_be", 32'(dbus_be), exp_be);
        check_eq("bus_wdata", dbus_wdata, exp_wd);
      end
    end
    dbus_ack = 1'b0;
    check_eq("done_stall", 32'(stall_mem), 32'd0);
    check_eq("done_err", 32'(access_err), 32'(tmo));
    if (!wr) model_result = tmo ? 32'd0 : expect_load(rdata, addr[1:0], f3);
    check_eq("result", mem_read_result, model_result);
    check_eq("req_cycles", 32'(req_cycles), 32'(exp_req));
    check_eq("stall_cycles", 32'(stall_cycles), 32'(exp_req + 1));
    @(negedge clk); idle_inputs(); #1;
    check_eq("idle_req", 32'(dbus_req), 32'd0);
    check_eq("idle_err", 32'(access_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    idle_inputs();
    dbus_ack = 1'b0;
    dbus_rdata = 32'd0;
    #1;
    check_eq("rst_req", 32'(dbus_req), 32'd0);
    check_eq("rst_stall", 32'(stall_mem), 32'd0);
    check_eq("rst_result", mem_read_result, 32'd0);
    check_eq("rst_addr", dbus_addr, 32'd0);
    check_eq("rst_be", 32'(dbus_be), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_txn(1'b1, 1'b0, 3'd2, 32'h0000_0100, 32'hA5A5_A5A5, 32'd0, 0);
    run_txn(1'b0, 1'b1, 3'd0, 32'h0000_0203, 32'd0, 32'h80FF_0000, 3);
    run_txn(1'b1, 1'b0, 3'd1, 32'h0000_0302, 32'h1234_BEEF, 32'd0, 1);
    run_txn(1'b0, 1'b1, 3'd5, 32'h0000_0302, 32'd0, 32'hBEEF_0000, 0);
    run_txn(1'b0, 1'b1, 3'd2, 32'h0000_0401, 32'd0, 32'd0, 0);
    run_txn(1'b0, 1'b1, 3'd2, 32'h0000_0404, 32'd0, 32'h1111_2222, 99);
    run_txn(1'b1, 1'b1, 3'd0, 32'h0000_0011, 32'h0000_0077, 32'd0, 2);

    // Reset pulled in the middle of a bus wait.
    @(negedge clk);
    mem_mem_read = 1'b1; mem_funct3 = 3'd2; mem_alu_result = 32'h0000_0500;
    repeat (2) @(negedge clk);
    #1;
    check_eq("mid_req_before", 32'(dbus_req), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("mid_req", 32'(dbus_req), 32'd0);
    check_eq("mid_stall", 32'(stall_mem), 32'd0);
    check_eq("mid_addr", dbus_addr, 32'd0);
    check_eq("mid_result", mem_read_result, 32'd0);
    model_result = 32'd0;
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    run_txn(1'b0, 1'b1, 3'd2, 32'h0000_0600, 32'd0, 32'hCAFE_F00D, 1);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] kind;
      kind = 2'($urandom_range(1, 3));
      run_txn(kind[1], kind[0], 3'($urandom_range(0, 7)),
              {$urandom_range(0, 65535), 2'($urandom_range(0, 3))},
              $urandom, $urandom, $urandom_range(0, 5));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
